// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// word geometry and the default memory depth.
package imem_loader_pkg;

   // Bytes assembled into one instruction word.
   localparam int BYTES_PER_WORD = 4;

   // Width of the byte index inside a word.
   localparam int BYTE_IDX_W = $clog2(BYTES_PER_WORD);

   // Default instruction-memory size in 32-bit words.
   localparam int DEFAULT_DEPTH = 64;

   // Loader session states.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_BYTE  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } state_e;

   // A session length is legal when it is non-zero and fits in the memory.
   function automatic logic len_ok(input logic [7:0] len, input int depth);
      logic [31:0] len_w;
      logic [31:0] depth_w;
      len_w   = {24'd0, len};
      depth_w = depth;
      return (len != 8'd0) && (len_w <= depth_w);
   endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Little-endian word assembler: each loaded byte enters at the top of a
// shift buffer, so after four loads the first byte sits in bits [7:0].
// The byte index wraps back to zero once a word is complete.
module imem_word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear_i,
   input  logic        load_i,
   input  logic [7:0]  data_i,
   output logic [31:0] word_o,
   output logic        full_o
);

   logic [31:0]           buf_q;
   logic [31:0]           buf_d;
   logic [31:0]           shifted;
   logic [BYTE_IDX_W-1:0] byte_idx_q;
   logic [BYTE_IDX_W-1:0] byte_idx_d;

   // Each lane takes the byte from the lane above; the top lane takes the
   // incoming byte.
   genvar gi;
   generate
      for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
         if (gi == BYTES_PER_WORD - 1) begin : g_top
            assign shifted[8*gi +: 8] = data_i;
         end else begin : g_mid
            assign shifted[8*gi +: 8] = buf_q[8*(gi+1) +: 8];
         end
      end
   endgenerate

   // Clear has priority over load so an aborted session never keeps a byte.
   always_comb begin
      buf_d      = buf_q;
      byte_idx_d = byte_idx_q;
      if (clear_i) begin
         buf_d      = '0;
         byte_idx_d = '0;
      end else if (load_i) begin
         buf_d      = shifted;
         byte_idx_d = byte_idx_q + 1'b1;
      end
   end

   // Buffer and index registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_q      <= '0;
         byte_idx_q <= '0;
      end else begin
         buf_q      <= buf_d;
         byte_idx_q <= byte_idx_d;
      end
   end

   // Full means the next loaded byte completes the word.
   assign full_o = (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
   assign word_o = buf_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length byte followed by
// 4*length payload bytes, writes the assembled little-endian words to
// consecutive word addresses and holds the CPU in reset meanwhile.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          abort,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          mem_we,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_wd,
   output logic          cpu_hold,
   output logic          done,
   output logic          error,
   output logic [AW:0]   words_written
);

   localparam int CW = AW + 1;

   state_e          state_q;
   state_e          state_d;
   logic [CW-1:0]   words_left_q;
   logic [CW-1:0]   words_left_d;
   logic [AW-1:0]   word_idx_q;
   logic [AW-1:0]   word_idx_d;
   logic [CW-1:0]   words_written_q;
   logic [CW-1:0]   words_written_d;
   logic            error_q;
   logic            error_d;

   logic            asm_clear;
   logic            asm_load;
   logic            asm_full;
   logic [31:0]     asm_word;

   // Ready depends only on state and abort, never on in_valid; an aborting
   // loader does not consume a byte.
   assign in_ready = ((state_q == ST_LEN) || (state_q == ST_BYTE)) && !abort;

   // A new session or an abort discards any partially assembled word.
   assign asm_clear = abort || ((state_q == ST_IDLE) && start);
   assign asm_load  = (state_q == ST_BYTE) && in_ready && in_valid;

   imem_word_assembler u_asm (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (asm_clear),
      .load_i  (asm_load),
      .data_i  (in_data),
      .word_o  (asm_word),
      .full_o  (asm_full)
   );

   // Next-state and strobe logic; abort overrides every transition.
   always_comb begin
      state_d         = state_q;
      words_left_d    = words_left_q;
      word_idx_d      = word_idx_q;
      words_written_d = words_written_q;
      error_d         = error_q;
      mem_we          = 1'b0;
      done            = 1'b0;

      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d         = ST_LEN;
                  error_d         = 1'b0;
                  words_written_d = '0;
                  word_idx_d      = '0;
                  words_left_d    = '0;
               end
            end
            ST_LEN: begin
               if (in_valid) begin
                  if (len_ok(in_data, DEPTH)) begin
                     words_left_d = CW'(in_data);
                     state_d      = ST_BYTE;
                  end else begin
                     state_d = ST_ERR;
                  end
               end
            end
            ST_BYTE: begin
               if (in_valid && asm_full) begin
                  state_d = ST_WRITE;
               end
            end
            ST_WRITE: begin
               mem_we          = 1'b1;
               words_written_d = words_written_q + 1'b1;
               words_left_d    = words_left_q - 1'b1;
               if (words_left_q == CW'(1)) begin
                  // Last word: keep the index in range instead of wrapping.
                  state_d = ST_DONE;
               end else begin
                  word_idx_d = word_idx_q + 1'b1;
                  state_d    = ST_BYTE;
               end
            end
            ST_DONE: begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
            ST_ERR: begin
               error_d = 1'b1;
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and session counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         words_left_q    <= '0;
         word_idx_q      <= '0;
         words_written_q <= '0;
         error_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         words_left_q    <= words_left_d;
         word_idx_q      <= word_idx_d;
         words_written_q <= words_written_d;
         error_q         <= error_d;
      end
   end

   assign cpu_hold      = (state_q != ST_IDLE);
   assign mem_addr      = {{(32-AW-2){1'b0}}, word_idx_q, 2'b00};
   assign mem_wd        = asm_word;
   assign error         = error_q;
   assign words_written = words_written_q;

endmodule
